cr_lz77_comp_ib_arb: RTL and testbench
======================================

// Module: cr_lz77_comp_ib_arb
// PURPOSE
// - Frame-granular round-robin arbiter sharing the single LZ77 compressor ingress among N AXI4-stream requesters.
// - Sits ahead of the compressor core's inbound port.
// - Grant is held from the first beat to the tlast beat, so frames never interleave.
// - Supports a software hold that drains the in-flight frame and then stops granting, for config updates.
// PARAMETERS
// - N_SRC       2   number of requesters, 2..8
// - DATA_W      64  tdata width per source
// - ID_W        3   width of dst_tid / active_id; must satisfy 2**ID_W >= N_SRC
// PORTS
// - clk               in   1            clock
// - rst               in   1            synchronous active-high reset
// - src_tvalid        in   N_SRC        per-source valid
// - src_tdata         in   N_SRC*DATA_W source i at [i*DATA_W +: DATA_W]
// - src_tlast         in   N_SRC        per-source end of frame
// - src_tready        out  N_SRC        per-source ready
// - dst_tvalid        out  1            to compressor ingress
// - dst_tdata         out  DATA_W       muxed data
// - dst_tlast         out  1            muxed tlast
// - dst_tid           out  ID_W         index of the granted source
// - dst_tready        in   1            compressor ready
// - cfg_hold          in   1            1 = no new grants
// - busy              out  1            frame in flight (state XFER)
// - active_id         out  ID_W         registered grant index
// - frame_done        out  1            1-cycle pulse on tlast handshake
// BEHAVIOUR
// - Reset values:
//   - state=IDLE; ptr=0; active_id=0; busy=0; frame_done=0.
//   - src_tready=0; dst_tvalid=0.
//   - dst_tdata, dst_tlast, dst_tid follow the mux of active_id, so dst_tdata = src0 data.
// - States: IDLE, XFER.
// - IDLE:
//   - All src_tready=0; dst_tvalid=0.
//   - If cfg_hold=0 and |src_tvalid: pick the first requesting index scanning ptr, ptr+1, ... mod N_SRC.
//   - Register that index into active_id and go to XFER next cycle (one idle cycle of arbitration latency).
// - XFER, zero-latency pass-through:
//   - dst_tvalid = src_tvalid[active_id]; dst_tdata and dst_tlast come from active_id.
//   - src_tready[active_id] = dst_tready; all other src_tready = 0.
//   - dst_tid = active_id.
// - Beat handshake: dst_tvalid & dst_tready.
// - On the handshake with dst_tlast=1:
//   - frame_done pulses next cycle (registered).
//   - ptr <= (active_id+1) mod N_SRC.
//   - state <= IDLE.
//   - A new grant is never issued in the same cycle; minimum 1 bubble between frames.
// - Grant stability:
//   - active_id is never changed in XFER, whatever happens to src_tvalid or cfg_hold.
//   - A source deasserting tvalid mid-frame stalls dst_tvalid but keeps the grant.
// - cfg_hold:
//   - Sampled in IDLE only.
//   - Asserted during XFER: the frame completes normally, then the block idles until hold=0.
// - Fairness: with every source continuously requesting, grants rotate 0,1,...,N_SRC-1,0; no source waits more than N_SRC-1 frames.
// - Single requester: re-granted every frame with a 1-cycle gap (ptr wraps past the others).
// - Wrap-around: ptr and the scan are mod N_SRC, not mod 2**ID_W; indices >= N_SRC are never granted.
// - Reset mid-frame:
//   - Returns to IDLE and ptr=0 on the next edge.
//   - The partial frame is abandoned; the upstream and downstream flush is owned by the system.
// - No combinational path from src_tvalid to src_tready.
// - dst_tready reaches src_tready combinationally, matching the core's handshake rules.
// TESTING
// - N_SRC=4, all tvalid=1, 3-beat frames, dst_tready=1 -> dst_tid sequence 0,1,2,3,0; frame_done x5; one idle cycle between frames.
// - Only src2 requests, 2-beat frames -> dst_tid=2 every frame; active_id stays 2; tready asserted only on bit 2.
// - src1 in XFER; src0 requesting; src1 drops tvalid 4 cycles mid-frame -> dst_tvalid=0 for those 4 cycles; grant stays 1; src0 tready=0 throughout.
// - dst_tready toggles 1,0,1,0 over an 8-beat frame -> dst_tdata matches the source order exactly; no beat lost or duplicated; tlast on beat 8 only.
// - cfg_hold=1 raised on beat 2 of a 5-beat frame -> all 5 beats delivered; then busy=0 and no grant; hold=0 -> next grant 1 cycle later to ptr-next.
// - rst=1 for 1 cycle mid-frame from src3 -> next cycle busy=0, all tready=0, active_id=0; the next grant scans from index 0.

Source files
------------

// File: rtl/cr_lz77_comp_ib_arb.sv
// -----------------------------------------------------------------------------
// cr_lz77_comp_ib_arb
//
// Frame-granular round-robin arbiter that shares the single LZ77 compressor
// ingress between N_SRC AXI4-stream requesters. A grant lasts from the first
// beat of a frame to its tlast beat, so frames from different sources never
// interleave. While cfg_hold is high no new grant is issued; a frame already in
// flight still runs to completion.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   src_tvalid      per-source valid                      [N_SRC]
//   src_tdata       source i at [i*DATA_W +: DATA_W]      [N_SRC*DATA_W]
//   src_tlast       per-source end of frame               [N_SRC]
//   src_tready      per-source ready                      [N_SRC]
//   dst_tvalid      valid toward the compressor ingress
//   dst_tdata       muxed data of the granted source      [DATA_W]
//   dst_tlast       muxed tlast of the granted source
//   dst_tid         index of the granted source           [ID_W]
//   dst_tready      compressor ready
//   cfg_hold        1 = issue no new grants
//   busy            a frame is in flight
//   active_id       registered grant index                [ID_W]
//   frame_done      one-cycle pulse after a tlast handshake
// -----------------------------------------------------------------------------
module cr_lz77_comp_ib_arb #(
  parameter int N_SRC  = 2,
  parameter int DATA_W = 64,
  parameter int ID_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SRC-1:0]        src_tvalid,
  input  logic [N_SRC*DATA_W-1:0] src_tdata,
  input  logic [N_SRC-1:0]        src_tlast,
  output logic [N_SRC-1:0]        src_tready,
  output logic                    dst_tvalid,
  output logic [DATA_W-1:0]       dst_tdata,
  output logic                    dst_tlast,
  output logic [ID_W-1:0]         dst_tid,
  input  logic                    dst_tready,
  input  logic                    cfg_hold,
  output logic                    busy,
  output logic [ID_W-1:0]         active_id,
  output logic                    frame_done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] active_id_q, active_id_d;
  logic            frame_done_q, frame_done_d;

  // One-hot decode of the registered grant; drives both the data mux and the
  // ready fan-out so that neither depends on src_tvalid.
  logic [N_SRC-1:0] sel_oh;
  logic [DATA_W-1:0] data_masked [N_SRC];
  logic             in_xfer;

  assign in_xfer = (state_q == S_XFER);

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign sel_oh[gi]      = (active_id_q == ID_W'(gi));
      assign data_masked[gi] = src_tdata[gi*DATA_W +: DATA_W] & {DATA_W{sel_oh[gi]}};
      // dst_tready passes straight through to the granted source only.
      assign src_tready[gi]  = in_xfer & sel_oh[gi] & dst_tready;
    end
  endgenerate

  // AND-OR data mux. Outside XFER it still follows active_id, so after reset
  // the output shows source 0.
  always_comb begin
    dst_tdata = '0;
    for (int k = 0; k < N_SRC; k++) begin
      dst_tdata = dst_tdata | data_masked[k];
    end
  end

  assign dst_tlast  = |(src_tlast & sel_oh);
  assign dst_tvalid = in_xfer & (|(src_tvalid & sel_oh));
  assign dst_tid    = active_id_q;

  logic hs_last;
  assign hs_last = dst_tvalid & dst_tready & dst_tlast;

  // Round-robin pick. Rotating a doubled request vector right by ptr puts the
  // highest-priority requester at bit 0; the lowest set bit is the offset from
  // ptr. Adding it back and wrapping at N_SRC (not 2**ID_W) gives the index.
  logic [N_SRC-1:0] req_rot;
  logic [ID_W:0]    grant_off;
  logic [ID_W:0]    grant_sum;
  logic [ID_W-1:0]  grant_idx;

  always_comb begin
    req_rot   = N_SRC'({src_tvalid, src_tvalid} >> ptr_q);
    grant_off = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        grant_off = (ID_W + 1)'(k);
      end
    end
    grant_sum = {1'b0, ptr_q} + grant_off;
    if (grant_sum >= (ID_W + 1)'(N_SRC)) begin
      grant_sum = grant_sum - (ID_W + 1)'(N_SRC);
    end
    grant_idx = ID_W'(grant_sum);
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    active_id_d  = active_id_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // cfg_hold is only looked at here; a frame in flight is never cut.
        if (!cfg_hold && (|src_tvalid)) begin
          active_id_d = grant_idx;
          state_d     = S_XFER;
        end
      end
      S_XFER: begin
        // The grant is frozen until the tlast handshake. Returning to IDLE
        // guarantees at least one bubble before the next frame.
        if (hs_last) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
          if (active_id_q == ID_W'(N_SRC - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = active_id_q + ID_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      active_id_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      active_id_q  <= active_id_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = in_xfer;
  assign active_id  = active_id_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cr_lz77_comp_ib_arb.sv
// -----------------------------------------------------------------------------
// tb_cr_lz77_comp_ib_arb
//
// Randomized bench for the ingress arbiter. Frames are loaded into per-source
// queues while the arbiter is idle; a frame-level round-robin model orders the
// same frames into an expected-beat queue. A driver process plays the source
// queues (random mid-frame valid gaps, random dst_tready); a monitor pops the
// expected queue on every dst handshake and compares.
// -----------------------------------------------------------------------------
module tb_cr_lz77_comp_ib_arb;

  localparam int N_SRC  = 4;
  localparam int DATA_W = 64;
  localparam int ID_W   = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_SRC-1:0]        src_tvalid;
  logic [N_SRC*DATA_W-1:0] src_tdata;
  logic [N_SRC-1:0]        src_tlast;
  logic [N_SRC-1:0]        src_tready;
  logic                    dst_tvalid;
  logic [DATA_W-1:0]       dst_tdata;
  logic                    dst_tlast;
  logic [ID_W-1:0]         dst_tid;
  logic                    dst_tready;
  logic                    cfg_hold;
  logic                    busy;
  logic [ID_W-1:0]         active_id;
  logic                    frame_done;

  always #5 clk = ~clk;

  cr_lz77_comp_ib_arb #(
    .N_SRC (N_SRC),
    .DATA_W(DATA_W),
    .ID_W  (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_tvalid(src_tvalid),
    .src_tdata (src_tdata),
    .src_tlast (src_tlast),
    .src_tready(src_tready),
    .dst_tvalid(dst_tvalid),
    .dst_tdata (dst_tdata),
    .dst_tlast (dst_tlast),
    .dst_tid   (dst_tid),
    .dst_tready(dst_tready),
    .cfg_hold  (cfg_hold),
    .busy      (busy),
    .active_id (active_id),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    int                tid;
  } beat_t;

  beat_t src_q [N_SRC][$];   // what each source still has to send
  beat_t mdl_q [N_SRC][$];   // same frames, consumed by the reference model
  beat_t exp_q [$];          // expected dst beats in order

  int checks     = 0;
  int errors     = 0;
  int beats_seen = 0;
  int mdl_ptr    = 0;
  int seq        = 0;
  int drop_pct   = 0;
  int rdy_pct    = 100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Whenever the ingress is free, the next frame belongs to the first source
  // at or after the pointer that still has frames; the pointer then moves one
  // past the winner.
  task automatic model_run();
    int idx;
    beat_t b;
    forever begin
      idx = -1;
      for (int k = 0; k < N_SRC; k++) begin
        int s;
        s = (mdl_ptr + k) % N_SRC;
        if (idx < 0 && mdl_q[s].size() > 0) idx = s;
      end
      if (idx < 0) break;
      do begin
        b     = mdl_q[idx].pop_front();
        b.tid = idx;
        exp_q.push_back(b);
      end while (!b.last);
      mdl_ptr = (idx + 1) % N_SRC;
    end
  endtask

  task automatic add_frame(input int s, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data = {8'(s), 24'(seq), $urandom};
      b.last = (j == len - 1);
      b.tid  = s;
      src_q[s].push_back(b);
      mdl_q[s].push_back(b);
    end
    seq++;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- driver
  logic [N_SRC-1:0] acc;
  logic [N_SRC-1:0] mid_frame;

  initial begin
    src_tvalid = '0;
    src_tdata  = '0;
    src_tlast  = '0;
    dst_tready = 1'b0;
    mid_frame  = '0;
    forever begin
      @(negedge clk);
      acc = src_tvalid & src_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_SRC; i++) begin
        if (rst) begin
          mid_frame[i] = 1'b0;
        end else if (acc[i] && src_q[i].size() > 0) begin
          mid_frame[i] = !src_q[i][0].last;
          void'(src_q[i].pop_front());
        end
        if (src_q[i].size() > 0) begin
          // first beat of a frame is always presented so arbitration is
          // deterministic; later beats may gap
          src_tvalid[i] = !mid_frame[i] || ($urandom_range(99) >= drop_pct);
          src_tdata[i*DATA_W +: DATA_W] = src_q[i][0].data;
          src_tlast[i] = src_q[i][0].last;
        end else begin
          src_tvalid[i] = 1'b0;
          src_tdata[i*DATA_W +: DATA_W] = {$urandom, $urandom};
          src_tlast[i] = 1'b0;
        end
      end
      dst_tready = ($urandom_range(99) < rdy_pct);
    end
  end

  // ---------------------------------------------------------------- monitor
  logic  prev_last_hs = 1'b0;
  logic  hs;
  beat_t e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_last_hs = 1'b0;
      end else begin
        if (prev_last_hs || frame_done) chk("frame_done", 64'(frame_done), 64'(prev_last_hs));
        if (prev_last_hs) chk("bubble_after_tlast", 64'(dst_tvalid), 64'd0);
        if (src_tready != '0) begin
          chk("tready_onehot", 64'($countones(src_tready)), 64'd1);
          chk("tready_needs_dst_tready", 64'(dst_tready), 64'd1);
        end
        if (busy && exp_q.size() > 0) begin
          chk("dst_tvalid_follows_grant", 64'(dst_tvalid), 64'(src_tvalid[exp_q[0].tid]));
        end
        hs = dst_tvalid && dst_tready;
        if (hs) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got tid %0d data %0h, required no beat", dst_tid, dst_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("dst_tid", 64'(dst_tid), 64'(e.tid));
            chk("dst_tdata", dst_tdata, e.data);
            chk("dst_tlast", 64'(dst_tlast), 64'(e.last));
            chk("active_id", 64'(active_id), 64'(e.tid));
            chk("src_tready", 64'(src_tready), 64'(N_SRC'(1) << e.tid));
            $display("beat tid=%0d data=%016h last=%0d", dst_tid, dst_tdata, dst_tlast);
          end
        end
        prev_last_hs = hs && dst_tlast;
      end
    end
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- main
  int base;
  int n;
  int hold_b;
  int mask;

  initial begin
    rst      = 1'b1;
    cfg_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_src_tready", 64'(src_tready), 64'd0);
    chk("rst_dst_tvalid", 64'(dst_tvalid), 64'd0);
    chk("rst_active_id", 64'(active_id), 64'd0);
    chk("rst_dst_tid", 64'(dst_tid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_dst_tdata_src0", dst_tdata, src_tdata[DATA_W-1:0]);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // all four sources, 3-beat frames, full throughput: 0,1,2,3,0,1,2,3
    drop_pct = 0;
    rdy_pct  = 100;
    for (int s = 0; s < N_SRC; s++) begin
      add_frame(s, 3);
      add_frame(s, 3);
    end
    model_run();
    wait_drain("drain_all_req");

    // single requester re-granted every frame
    for (int f = 0; f < 3; f++) add_frame(2, 2);
    model_run();
    wait_drain("drain_single_src2");

    // randomized phases with mid-frame gaps and dst back-pressure
    drop_pct = 30;
    rdy_pct  = 60;
    for (int p = 0; p < 20; p++) begin
      mask = $urandom_range(15, 1);
      for (int s = 0; s < N_SRC; s++) begin
        if (mask[s]) begin
          n = $urandom_range(3, 1);
          for (int f = 0; f < n; f++) add_frame(s, $urandom_range(8, 1));
        end
      end
      model_run();
      wait_drain("drain_random");
    end

    // cfg_hold raised mid-frame: frame finishes, then no grant until release
    drop_pct = 0;
    rdy_pct  = 100;
    hold_b   = (mdl_ptr + 2) % N_SRC;
    add_frame(mdl_ptr, 5);
    add_frame(hold_b, 3);
    base = beats_seen;
    model_run();
    n = 0;
    while (beats_seen < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    cfg_hold = 1'b1;
    n = 0;
    while (exp_q.size() > 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("hold_busy", 64'(busy), 64'd0);
    chk("hold_dst_tvalid", 64'(dst_tvalid), 64'd0);
    chk("hold_pending_beats", 64'(exp_q.size()), 64'd3);
    @(posedge clk);
    #2 cfg_hold = 1'b0;
    @(negedge clk);
    chk("hold_release_latency", 64'(busy), 64'd0);
    @(negedge clk);
    chk("hold_release_grant", 64'(busy), 64'd1);
    chk("hold_release_tid", 64'(dst_tid), 64'(hold_b));
    wait_drain("drain_hold");

    // leave ptr at 2, start a long src3 frame, then reset in the middle
    add_frame(1, 2);
    model_run();
    wait_drain("drain_pre_reset");
    add_frame(3, 10);
    base = beats_seen;
    model_run();
    n = 0;
    while (beats_seen < base + 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    for (int s = 0; s < N_SRC; s++) begin
      src_q[s].delete();
      mdl_q[s].delete();
    end
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    mdl_ptr = 0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_src_tready", 64'(src_tready), 64'd0);
    chk("midrst_active_id", 64'(active_id), 64'd0);
    chk("midrst_dst_tvalid", 64'(dst_tvalid), 64'd0);
    chk("midrst_frame_done", 64'(frame_done), 64'd0);
    // with the pointer back at 0, source 1 must win over source 3
    add_frame(3, 2);
    add_frame(1, 2);
    model_run();
    wait_drain("drain_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
